// File: rtl/cray_scalar_pkg.sv
// ---------------------------------------------------------------------------
// cray_scalar_pkg
// Shared definitions for the scalar/address result write-back path:
//   - functional-unit select codes and their fixed latencies
//   - field widths and the record kept in each latency slot
// No ports (package).
// ---------------------------------------------------------------------------
package cray_scalar_pkg;

    localparam int DEST_W = 3;            // A register index width
    localparam int SRC_W  = 2;            // result source select width
    localparam int LAT_W  = 4;            // issue latency field width
    localparam int NREG   = 1 << DEST_W;  // number of A registers

    typedef enum logic [SRC_W-1:0] {
        FU_POPLZ = 2'd0,
        FU_AADD  = 2'd1,
        FU_AMUL  = 2'd2,
        FU_SPARE = 2'd3
    } fu_sel_e;

    localparam int LAT_POPLZ = 4;
    localparam int LAT_AADD  = 2;
    localparam int LAT_AMUL  = 6;

    // One pending result: where it goes and which unit bus produces it.
    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic [SRC_W-1:0]  src;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/a_result_writeback_if.sv
// ---------------------------------------------------------------------------
// a_result_writeback_if
// Issue handshake, unit result buses and A-file write port of the A result
// write-back tracker.
//   master : issue logic / testbench side (drives requests and unit results)
//   slave  : the tracker (answers o_issue_ok, drives write port and o_a_resv)
// Signals:
//   i_issue, i_issue_dest[2:0], i_issue_src[1:0], i_issue_lat[3:0]  request
//   o_issue_ok                         request accepted this cycle (comb.)
//   i_fu_result[NSRC*AW-1:0]           unit s result at [s*AW +: AW]
//   o_a_we, o_a_waddr[2:0], o_a_wdata  registered A-file write port
//   o_a_resv[7:0]                      per-register reservation bits
// ---------------------------------------------------------------------------
interface a_result_writeback_if #(
    parameter int NSRC = 4,
    parameter int AW   = 24
);
    import cray_scalar_pkg::*;

    logic                 i_issue;
    logic [DEST_W-1:0]    i_issue_dest;
    logic [SRC_W-1:0]     i_issue_src;
    logic [LAT_W-1:0]     i_issue_lat;
    logic                 o_issue_ok;
    logic [NSRC*AW-1:0]   i_fu_result;
    logic                 o_a_we;
    logic [DEST_W-1:0]    o_a_waddr;
    logic [AW-1:0]        o_a_wdata;
    logic [NREG-1:0]      o_a_resv;

    modport master (
        output i_issue, i_issue_dest, i_issue_src, i_issue_lat, i_fu_result,
        input  o_issue_ok, o_a_we, o_a_waddr, o_a_wdata, o_a_resv
    );

    modport slave (
        input  i_issue, i_issue_dest, i_issue_src, i_issue_lat, i_fu_result,
        output o_issue_ok, o_a_we, o_a_waddr, o_a_wdata, o_a_resv
    );

endinterface

// File: rtl/a_result_writeback_slot.sv
// ---------------------------------------------------------------------------
// a_wb_slot
// One position of the latency slot line. Each clock it either captures a
// newly issued entry (load) or takes the entry shifting down from the slot
// above it.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_entry this edge (issue with matching latency)
//   load_entry   record of the accepted instruction
//   next_entry   record of the slot one position higher (empty for the top)
//   entry        current slot contents
// ---------------------------------------------------------------------------
module a_wb_slot
    import cray_scalar_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  slot_t load_entry,
    input  slot_t next_entry,
    output slot_t entry
);

    // NOTE: every slot is reset, not just valid bits of a RAM-like array:
    // a reset must drop in-flight results so nothing is written afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= SLOT_EMPTY;
        end else if (load) begin
            // NOTE: non-blocking so every slot sees its neighbour's old value
            // and the whole line shifts by exactly one position per edge.
            entry <= load_entry;
        end else begin
            entry <= next_entry;
        end
    end

endmodule

// File: rtl/a_result_writeback.sv
// ---------------------------------------------------------------------------
// a_result_writeback
// Result write-back tracker for the A register file. Functional units return
// untagged results after a fixed latency; this block remembers, per future
// cycle, which unit's bus to sample and which Ai to write, and keeps the
// reservation bits that issue uses as its RAW/WAW interlock.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          a_result_writeback_if.slave (issue handshake, unit results,
//                registered A write port, reservation bits)
// Parameters: MAX_LAT (slot count), NSRC (result sources), AW (A width)
// Configuration macro RESV_EARLY_RELEASE_EN:
//   defined   - reservation released at the edge ending the retire cycle,
//               so o_a_resv[d] is already 0 while o_a_we is high
//   undefined - reservation released one cycle later (after the write)
// ---------------------------------------------------------------------------
module a_result_writeback
    import cray_scalar_pkg::*;
#(
    parameter int MAX_LAT = 8,
    parameter int NSRC    = 4,
    parameter int AW      = 24
) (
    input logic             clk,
    input logic             rst_n,
    a_result_writeback_if.slave bus
);

    slot_t             slots [MAX_LAT];
    slot_t             new_entry;
    logic              lat_ok;
    logic              src_ok;
    logic              port_busy;
    logic              accept;
    logic [AW-1:0]     ret_data;
    logic [NREG-1:0]   resv_set;
    logic [NREG-1:0]   resv_clr;

    logic              a_we;
    logic [DEST_W-1:0] a_waddr;
    logic [AW-1:0]     a_wdata;
    logic [NREG-1:0]   a_resv;

    // Issue check. slot[L] holds whatever retires in the same cycle as this
    // request would; it must be empty since there is a single write port.
    // L == MAX_LAT lands in the top slot, which always shifts in empty.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        lat_ok    = (bus.i_issue_lat != '0) && (int'(bus.i_issue_lat) <= MAX_LAT);
        port_busy = 1'b0;
        for (int k = 1; k < MAX_LAT; k++) begin
            if (bus.i_issue_lat == LAT_W'(k)) port_busy = slots[k].valid;
        end
        src_ok = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (bus.i_issue_src == SRC_W'(s)) src_ok = 1'b1;
        end
        accept = bus.i_issue && lat_ok && src_ok && !port_busy
                 && !a_resv[bus.i_issue_dest];
    end

    assign new_entry = '{valid: 1'b1, dest: bus.i_issue_dest, src: bus.i_issue_src};

    // Latency slot line: slot[L-1] loads on accept, everything else shifts down.
    for (genvar k = 0; k < MAX_LAT; k++) begin : g_slot
        slot_t next_in;
        if (k == MAX_LAT - 1) begin : g_top
            assign next_in = SLOT_EMPTY;
        end else begin : g_mid
            assign next_in = slots[k+1];
        end
        a_wb_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (accept && (bus.i_issue_lat == LAT_W'(k + 1))),
            .load_entry (new_entry),
            .next_entry (next_in),
            .entry      (slots[k])
        );
    end

    // Retire mux: slot[0] names the unit whose bus carries the result now.
    always_comb begin
        ret_data = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (slots[0].src == SRC_W'(s)) ret_data = bus.i_fu_result[s*AW +: AW];
        end
    end

    always_comb begin
        resv_set = '0;
        resv_clr = '0;
        if (accept) resv_set[bus.i_issue_dest] = 1'b1;
`ifdef RESV_EARLY_RELEASE_EN
        if (slots[0].valid) resv_clr[slots[0].dest] = 1'b1;
`else
        if (a_we) resv_clr[a_waddr] = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_we    <= 1'b0;
            a_waddr <= '0;
            a_wdata <= '0;
            a_resv  <= '0;
        end else begin
            a_we <= slots[0].valid;
            if (slots[0].valid) begin
                a_waddr <= slots[0].dest;
                a_wdata <= ret_data;
            end
            // A new reservation outranks a release in the same edge.
            a_resv <= (a_resv & ~resv_clr) | resv_set;
        end
    end

    assign bus.o_issue_ok = accept;
    assign bus.o_a_we     = a_we;
    assign bus.o_a_waddr  = a_waddr;
    assign bus.o_a_wdata  = a_wdata;
    assign bus.o_a_resv   = a_resv;

endmodule

// File: tb/tb_a_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_a_result_writeback
// Self-checking bench for a_result_writeback (NSRC=3 so source 3 is illegal).
// Reference model: a schedule keyed by absolute cycle number (retire cycle ->
// dest/src, write cycle -> addr/data) plus the last reserved cycle of each
// register. Directed steps first, then a randomized phase.
// ---------------------------------------------------------------------------
module tb_a_result_writeback;
    import cray_scalar_pkg::*;

    localparam int MAX_LAT = 8;
    localparam int NSRC    = 3;
    localparam int AW      = 24;
`ifdef RESV_EARLY_RELEASE_EN
    localparam int RESV_TAIL = 0;
`else
    localparam int RESV_TAIL = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a_result_writeback_if #(.NSRC(NSRC), .AW(AW)) bus ();

    a_result_writeback #(.MAX_LAT(MAX_LAT), .NSRC(NSRC), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int ret_dest [int];     // retire cycle -> destination
    int ret_src  [int];     // retire cycle -> source unit
    int wr_addr  [int];     // cycle with o_a_we expected -> address
    int wr_data  [int];     // cycle with o_a_we expected -> data
    int resv_end [NREG];    // last cycle register d reads as reserved
    bit dut_ok;
    int writes_seen;
    int wr_log [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        ret_dest.delete();
        ret_src.delete();
        wr_addr.delete();
        wr_data.delete();
        foreach (resv_end[d]) resv_end[d] = -1;
    endtask

    task automatic new_inputs();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        bus.i_fu_result = r[NSRC*AW-1:0];
        bus.i_issue     = 1'b0;
    endtask

    task automatic req(input int d, input int s, input int l);
        bus.i_issue      = 1'b1;
        bus.i_issue_dest = 3'(d);
        bus.i_issue_src  = 2'(s);
        bus.i_issue_lat  = 4'(l);
    endtask

    // One clock: compare everything at the falling edge, advance the model,
    // then move past the rising edge and present fresh idle inputs.
    task automatic tick();
        bit              exp_ok;
        int              d, s, l;
        logic [NREG-1:0] exp_resv;
        @(negedge clk);
        d = int'(bus.i_issue_dest);
        s = int'(bus.i_issue_src);
        l = int'(bus.i_issue_lat);
        exp_ok = bus.i_issue && (l >= 1) && (l <= MAX_LAT) && (s < NSRC)
                 && !ret_dest.exists(cyc + l) && !(cyc <= resv_end[d]);
        dut_ok = bus.o_issue_ok;
        check("issue_ok", 32'(bus.o_issue_ok), 32'(exp_ok));
        check("a_we", 32'(bus.o_a_we), 32'(wr_addr.exists(cyc)));
        if (wr_addr.exists(cyc)) begin
            check("a_waddr", 32'(bus.o_a_waddr), 32'(wr_addr[cyc]));
            check("a_wdata", 32'(bus.o_a_wdata), 32'(wr_data[cyc]));
        end
        if (bus.o_a_we === 1'b1) begin
            writes_seen++;
            wr_log.push_back(int'(bus.o_a_waddr));
        end
        exp_resv = '0;
        for (int r = 0; r < NREG; r++) exp_resv[r] = (cyc <= resv_end[r]);
        check("a_resv", 32'(bus.o_a_resv), 32'(exp_resv));
        if (ret_dest.exists(cyc)) begin
            wr_addr[cyc + 1] = ret_dest[cyc];
            wr_data[cyc + 1] = int'(bus.i_fu_result[ret_src[cyc]*AW +: AW]);
            ret_dest.delete(cyc);
            ret_src.delete(cyc);
        end
        if (exp_ok) begin
            ret_dest[cyc + l] = d;
            ret_src[cyc + l]  = s;
            resv_end[d]       = cyc + l + RESV_TAIL;
        end
        @(posedge clk);
        #1;
        cyc++;
        new_inputs();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.i_issue = 1'b0;
        #1;
        check("rst_we",    32'(bus.o_a_we),    32'd0);
        check("rst_waddr", 32'(bus.o_a_waddr), 32'd0);
        check("rst_wdata", 32'(bus.o_a_wdata), 32'd0);
        check("rst_resv",  32'(bus.o_a_resv),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        model_clear();
    endtask

    initial begin
        int t0;
        int accepted;
        bus.i_issue_dest = '0;
        bus.i_issue_src  = '0;
        bus.i_issue_lat  = '0;
        new_inputs();
        model_clear();
        writes_seen = 0;
        do_reset();
        repeat (2) tick();

        // Pop count: dest 3, unit 0, L=4, result 24'h2A on the retire cycle.
        req(3, FU_POPLZ, LAT_POPLZ);
        t0 = cyc;
        tick();
        repeat (LAT_POPLZ + 2) begin
            if (cyc == t0 + LAT_POPLZ) bus.i_fu_result[AW-1:0] = 24'h00002A;
            tick();
            if (cyc == t0 + LAT_POPLZ + 1) begin
                check("pop_we",    32'(bus.o_a_we),    32'd1);
                check("pop_waddr", 32'(bus.o_a_waddr), 32'd3);
                check("pop_wdata", 32'(bus.o_a_wdata), 32'h00002A);
            end
        end
        repeat (3) tick();

        // Port collision: L=6 at c, L=4 at c+2 collides; L=3 is accepted.
        req(1, FU_AMUL, LAT_AMUL);
        tick();
        tick();
        req(2, FU_AADD, 4);
        #1;
        check("collision_rej", 32'(bus.o_issue_ok), 32'd0);
        bus.i_issue_lat = 4'd3;
        tick();
        check("collision_acc", 32'(dut_ok), 32'd1);
        repeat (9) tick();

        // Interlock: second request to dest 5 held until resv[5] drops.
        req(5, FU_AADD, 3);
        t0 = cyc;
        tick();
        accepted = -100;
        for (int i = 0; i < 12; i++) begin
            int c;
            c = cyc;
            req(5, FU_AADD, 2);
            tick();
            if (dut_ok) begin
                accepted = c;
                break;
            end
        end
        check("interlock_wait", 32'(accepted - t0), 32'(4 + RESV_TAIL));
        repeat (6) tick();

        // Illegal requests: no acceptance, no state change.
        req(0, FU_POPLZ, 0);
        #1;
        check("illegal_l0", 32'(bus.o_issue_ok), 32'd0);
        tick();
        req(1, FU_POPLZ, MAX_LAT + 1);
        #1;
        check("illegal_l9", 32'(bus.o_issue_ok), 32'd0);
        tick();
        req(2, FU_SPARE, 2);
        #1;
        check("illegal_src", 32'(bus.o_issue_ok), 32'd0);
        tick();
        repeat (4) tick();

        // Stream: eight consecutive L=4 accepts to dests 0..7.
        wr_log.delete();
        for (int d = 0; d < 8; d++) begin
            req(d, d % NSRC, 4);
            tick();
        end
        repeat (8) tick();
        check("stream_count", 32'(wr_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
            check("stream_addr", 32'(wr_log[i]), 32'(i));
        end
        repeat (3) tick();

        // Reset mid-flight with two entries pending.
        req(6, FU_AMUL, 5);
        tick();
        req(7, FU_AADD, 7);
        tick();
        tick();
        do_reset();
        writes_seen = 0;
        repeat (12) tick();
        check("post_rst_writes", 32'(writes_seen), 32'd0);
        check("post_rst_resv",   32'(bus.o_a_resv), 32'd0);

        // Randomized traffic, including illegal latencies and source 3.
        repeat (400) begin
            if ($urandom_range(0, 2) != 0) begin
                req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 9)));
            end
            tick();
        end
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
